// File: rtl/sr_pq_gen_pkg.sv
// Shared definitions for the generic shift-register priority queue.
// Holds default sizes, the ordering/stage-select enums and the key compare helper.
// Pure declarations: no logic, no latency, no flow control.
package sr_pq_gen_pkg;

   localparam int PQ_KW       = 16;
   localparam int PQ_VW       = 16;
   localparam int PQ_CAPACITY = 8;

   // Keys are zero-extended to this width before comparison, so KW must not exceed it.
   localparam int PQ_KEY_MAXW = 64;

   typedef enum logic {
      PQ_MIN = 1'b0,
      PQ_MAX = 1'b1
   } pq_order_e;

   // Per-stage next-content source.
   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_PREV = 2'd1,
      SEL_NEXT = 2'd2,
      SEL_NEW  = 2'd3
   } pq_sel_e;

   // Strict "a belongs ahead of b" for the chosen ordering; ties are never better,
   // which is what keeps equal keys in arrival order.
   function automatic logic pq_better(input logic [PQ_KEY_MAXW-1:0] a,
                                      input logic [PQ_KEY_MAXW-1:0] b,
                                      input pq_order_e               ord);
      return (ord == PQ_MAX) ? (a > b) : (a < b);
   endfunction

endpackage

// File: rtl/sr_pq_gen_stage.sv
// One queue stage: holds valid/key/value and picks hold, prev, next or new content.
// Latency: new content is registered on the clock edge after push/pop is sampled.
// Backpressure: none; the stage follows the push/pop strobes and neighbour flags every cycle.
// Ports: clk/rst, push/pop/ki/vi broadcast, neighbour insert flags, neighbour entries,
//        own insert flag and current entry.
module sr_pq_gen_stage
   import sr_pq_gen_pkg::*;
#(
   parameter int KW        = PQ_KW,
   parameter int VW        = PQ_VW,
   parameter int MAX_FIRST = 0,
   parameter int IS_HEAD   = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [KW-1:0] ki,
   input  logic [VW-1:0] vi,
   input  logic          flag_prev,
   input  logic          flag_next,
   input  logic          prev_valid,
   input  logic [KW-1:0] prev_k,
   input  logic [VW-1:0] prev_v,
   input  logic          next_valid,
   input  logic [KW-1:0] next_k,
   input  logic [VW-1:0] next_v,
   output logic          flag,
   output logic          valid,
   output logic [KW-1:0] key,
   output logic [VW-1:0] val
);

   localparam pq_order_e ORD  = (MAX_FIRST != 0) ? PQ_MAX : PQ_MIN;
   localparam logic      HEAD = (IS_HEAD != 0);

   logic          valid_q, valid_d;
   logic [KW-1:0] key_q, key_d;
   logic [VW-1:0] val_q, val_d;
   pq_sel_e       sel;

   // Flags are monotone along the array (0..0 1..1): the first set flag is the insert index.
   assign flag = !valid_q ||
                 pq_better(PQ_KEY_MAXW'(ki), PQ_KEY_MAXW'(key_q), ORD);

   always_comb begin
      sel = SEL_HOLD;
      if (push && pop) begin
         // Replace: target q = max(p-1,0). Stages before q shift toward the head,
         // stage q takes the new entry, later stages keep their contents.
         if (!flag_next)
            sel = SEL_NEXT;
         else if (!flag || HEAD)
            sel = SEL_NEW;
      end else if (push) begin
         // Full with no better slot leaves every flag clear, so nothing moves.
         if (flag_prev)
            sel = SEL_PREV;
         else if (flag)
            sel = SEL_NEW;
      end else if (pop) begin
         sel = SEL_NEXT;
      end
   end

   // Moving in an invalid neighbour only clears valid; key/value keep their last
   // contents so the head outputs hold steady once the queue drains.
   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      val_d   = val_q;
      unique case (sel)
         SEL_PREV: begin
            valid_d = prev_valid;
            if (prev_valid) begin
               key_d = prev_k;
               val_d = prev_v;
            end
         end
         SEL_NEXT: begin
            valid_d = next_valid;
            if (next_valid) begin
               key_d = next_k;
               val_d = next_v;
            end
         end
         SEL_NEW: begin
            valid_d = 1'b1;
            key_d   = ki;
            val_d   = vi;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         key_q   <= '0;
         val_q   <= '0;
      end else begin
         valid_q <= valid_d;
         key_q   <= key_d;
         val_q   <= val_d;
      end
   end

   assign valid = valid_q;
   assign key   = key_q;
   assign val   = val_q;

endmodule

// File: rtl/sr_pq_gen.sv
// Shift-register priority queue with min/max order, FIFO ties, replace and eviction.
// Latency: one cycle from push/pop to head, count, evict and underflow outputs; all registered.
// Backpressure: none; a push when full evicts the worst entry (or rejects the new one).
// Ports: clk/rst, push/pop/ki/vi in; ko/vo/ko_valid head, full/empty/count,
//        evict_valid/evict_k/evict_v and underflow pulses out.
module sr_pq_gen
   import sr_pq_gen_pkg::*;
#(
   parameter int KW        = PQ_KW,
   parameter int VW        = PQ_VW,
   parameter int DEPTH     = PQ_CAPACITY,
   parameter int MAX_FIRST = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [KW-1:0]                ki,
   input  logic [VW-1:0]                vi,
   output logic [KW-1:0]                ko,
   output logic [VW-1:0]                vo,
   output logic                         ko_valid,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         evict_valid,
   output logic [KW-1:0]                evict_k,
   output logic [VW-1:0]                evict_v,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH+1);

   // Stage j lives at index j+1; index 0 and DEPTH+1 are the array boundaries.
   // Boundary flags: nothing ahead of the head shifts in (0); past the tail acts as
   // an always-insertable slot (1) so a full-queue replace targets the last stage.
   logic [DEPTH+1:0] flag_ext;
   logic [DEPTH+1:0] valid_ext;
   logic [KW-1:0]    key_ext [DEPTH+2];
   logic [VW-1:0]    val_ext [DEPTH+2];

   assign flag_ext[0]        = 1'b0;
   assign flag_ext[DEPTH+1]  = 1'b1;
   assign valid_ext[0]       = 1'b0;
   assign valid_ext[DEPTH+1] = 1'b0;
   assign key_ext[0]         = '0;
   assign key_ext[DEPTH+1]   = '0;
   assign val_ext[0]         = '0;
   assign val_ext[DEPTH+1]   = '0;

   for (genvar j = 0; j < DEPTH; j++) begin : g_stage
      sr_pq_gen_stage #(
         .KW        (KW),
         .VW        (VW),
         .MAX_FIRST (MAX_FIRST),
         .IS_HEAD   ((j == 0) ? 1 : 0)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .push       (push),
         .pop        (pop),
         .ki         (ki),
         .vi         (vi),
         .flag_prev  (flag_ext[j]),
         .flag_next  (flag_ext[j+2]),
         .prev_valid (valid_ext[j]),
         .prev_k     (key_ext[j]),
         .prev_v     (val_ext[j]),
         .next_valid (valid_ext[j+2]),
         .next_k     (key_ext[j+2]),
         .next_v     (val_ext[j+2]),
         .flag       (flag_ext[j+1]),
         .valid      (valid_ext[j+1]),
         .key        (key_ext[j+1]),
         .val        (val_ext[j+1])
      );
   end

   logic [CW-1:0] count_q, count_d;
   logic          evict_valid_q, evict_valid_d;
   logic [KW-1:0] evict_k_q, evict_k_d;
   logic [VW-1:0] evict_v_q, evict_v_d;
   logic          underflow_q, underflow_d;
   logic          full_w, empty_w;

   assign full_w  = (count_q == CW'(DEPTH));
   assign empty_w = (count_q == '0);

   always_comb begin
      count_d       = count_q;
      evict_valid_d = 1'b0;
      evict_k_d     = evict_k_q;
      evict_v_d     = evict_v_q;
      underflow_d   = pop && empty_w;
      if (push && !pop) begin
         if (!full_w) begin
            count_d = count_q + CW'(1);
         end else begin
            evict_valid_d = 1'b1;
            // Last stage's flag set means the new key found a slot and the tail drops out;
            // otherwise the new entry itself is rejected.
            if (flag_ext[DEPTH]) begin
               evict_k_d = key_ext[DEPTH];
               evict_v_d = val_ext[DEPTH];
            end else begin
               evict_k_d = ki;
               evict_v_d = vi;
            end
         end
      end else if (pop && !push) begin
         if (!empty_w)
            count_d = count_q - CW'(1);
      end else if (push && pop) begin
         if (empty_w)
            count_d = CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q       <= '0;
         evict_valid_q <= 1'b0;
         evict_k_q     <= '0;
         evict_v_q     <= '0;
         underflow_q   <= 1'b0;
      end else begin
         count_q       <= count_d;
         evict_valid_q <= evict_valid_d;
         evict_k_q     <= evict_k_d;
         evict_v_q     <= evict_v_d;
         underflow_q   <= underflow_d;
      end
   end

   assign ko          = key_ext[1];
   assign vo          = val_ext[1];
   assign ko_valid    = valid_ext[1];
   assign count       = count_q;
   assign full        = full_w;
   assign empty       = empty_w;
   assign evict_valid = evict_valid_q;
   assign evict_k     = evict_k_q;
   assign evict_v     = evict_v_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_sr_pq_gen.sv
// Directed bench for sr_pq_gen: min-order instance (u_min) and max-order instance (u_max).
// Inputs change #1 after each rising edge; outputs are checked #1 after the edge.
module tb_sr_pq_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] ki = '0;
   logic [7:0] vi = '0;

   logic [7:0] ko0, vo0, ek0, ev0;
   logic       kv0, full0, empty0, evv0, uf0;
   logic [2:0] cnt0;
   logic [7:0] ko1, vo1, ek1, ev1;
   logic       kv1, full1, empty1, evv1, uf1;
   logic [2:0] cnt1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sr_pq_gen #(.KW(8), .VW(8), .DEPTH(4), .MAX_FIRST(0)) u_min (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .ki(ki), .vi(vi),
      .ko(ko0), .vo(vo0), .ko_valid(kv0), .full(full0), .empty(empty0), .count(cnt0),
      .evict_valid(evv0), .evict_k(ek0), .evict_v(ev0), .underflow(uf0)
   );

   sr_pq_gen #(.KW(8), .VW(8), .DEPTH(4), .MAX_FIRST(1)) u_max (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .ki(ki), .vi(vi),
      .ko(ko1), .vo(vo1), .ko_valid(kv1), .full(full1), .empty(empty1), .count(cnt1),
      .evict_valid(evv1), .evict_k(ek1), .evict_v(ev1), .underflow(uf1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes; returns #1 after the edge with strobes idle.
   task automatic cyc(input logic p, input logic o, input logic [7:0] k, input logic [7:0] v);
      push = p;
      pop  = o;
      ki   = k;
      vi   = v;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc(1'b0, 1'b0, 8'd0, 8'd0);
      rst = 1'b1;
   endtask

   initial begin
      // Reset state
      rst = 1'b0;
      cyc(1'b0, 1'b0, 8'd0, 8'd0);
      cyc(1'b0, 1'b0, 8'd0, 8'd0);
      chk("rst_count",    16'(cnt0),  16'd0);
      chk("rst_empty",    16'(empty0), 16'd1);
      chk("rst_full",     16'(full0),  16'd0);
      chk("rst_ko_valid", 16'(kv0),    16'd0);
      chk("rst_ko",       16'(ko0),    16'd0);
      chk("rst_vo",       16'(vo0),    16'd0);
      chk("rst_evict",    16'(evv0),   16'd0);
      chk("rst_evict_k",  16'(ek0),    16'd0);
      chk("rst_uf",       16'(uf0),    16'd0);
      rst = 1'b1;

      // Sorted insert: 30,10,20
      cyc(1'b1, 1'b0, 8'd30, 8'd31);
      chk("ins1_ko",    16'(ko0),  16'd30);
      chk("ins1_count", 16'(cnt0), 16'd1);
      cyc(1'b1, 1'b0, 8'd10, 8'd11);
      cyc(1'b1, 1'b0, 8'd20, 8'd21);
      chk("ins3_ko",    16'(ko0),    16'd10);
      chk("ins3_vo",    16'(vo0),    16'd11);
      chk("ins3_count", 16'(cnt0),   16'd3);
      chk("ins3_empty", 16'(empty0), 16'd0);
      chk("ins3_full",  16'(full0),  16'd0);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("ins_pop1_ko", 16'(ko0), 16'd20);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("ins_pop2_ko", 16'(ko0), 16'd30);

      // Ties stay in arrival order
      do_reset();
      cyc(1'b1, 1'b0, 8'd5, 8'hA1);
      cyc(1'b1, 1'b0, 8'd5, 8'hB2);
      chk("tie_vo_a",   16'(vo0),  16'hA1);
      chk("tie_count2", 16'(cnt0), 16'd2);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("tie_vo_b",   16'(vo0),  16'hB2);
      chk("tie_count1", 16'(cnt0), 16'd1);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("tie_count0", 16'(cnt0),   16'd0);
      chk("tie_empty",  16'(empty0), 16'd1);
      chk("tie_kv",     16'(kv0),    16'd0);
      chk("tie_vo_hold",16'(vo0),    16'hB2);
      chk("tie_uf",     16'(uf0),    16'd0);

      // Full: eviction of the tail, then rejection of a worse key
      do_reset();
      cyc(1'b1, 1'b0, 8'd10, 8'd11);
      cyc(1'b1, 1'b0, 8'd20, 8'd21);
      cyc(1'b1, 1'b0, 8'd30, 8'd31);
      cyc(1'b1, 1'b0, 8'd40, 8'd41);
      chk("fill_full",  16'(full0), 16'd1);
      chk("fill_count", 16'(cnt0),  16'd4);
      chk("fill_evv",   16'(evv0),  16'd0);
      cyc(1'b1, 1'b0, 8'd15, 8'd16);
      chk("ev_valid", 16'(evv0), 16'd1);
      chk("ev_k",     16'(ek0),  16'd40);
      chk("ev_v",     16'(ev0),  16'd41);
      chk("ev_count", 16'(cnt0), 16'd4);
      chk("ev_ko",    16'(ko0),  16'd10);
      cyc(1'b0, 1'b0, 8'd0, 8'd0);
      chk("ev_pulse_end", 16'(evv0), 16'd0);
      cyc(1'b1, 1'b0, 8'd50, 8'd51);
      chk("rej_valid", 16'(evv0), 16'd1);
      chk("rej_k",     16'(ek0),  16'd50);
      chk("rej_v",     16'(ev0),  16'd51);
      chk("rej_count", 16'(cnt0), 16'd4);
      chk("rej_ko",    16'(ko0),  16'd10);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("ev_pop1", 16'(ko0), 16'd15);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("ev_pop2", 16'(ko0), 16'd20);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("ev_pop3", 16'(ko0), 16'd30);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("ev_pop4_empty", 16'(empty0), 16'd1);

      // Replace (push+pop)
      do_reset();
      cyc(1'b1, 1'b0, 8'd10, 8'd11);
      cyc(1'b1, 1'b0, 8'd20, 8'd21);
      cyc(1'b1, 1'b0, 8'd30, 8'd31);
      cyc(1'b1, 1'b1, 8'd25, 8'd26);
      chk("rep1_ko",    16'(ko0),  16'd20);
      chk("rep1_count", 16'(cnt0), 16'd3);
      chk("rep1_evv",   16'(evv0), 16'd0);
      cyc(1'b1, 1'b1, 8'd5, 8'd6);
      chk("rep2_ko",    16'(ko0),  16'd5);
      chk("rep2_vo",    16'(vo0),  16'd6);
      chk("rep2_count", 16'(cnt0), 16'd3);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("rep_pop1", 16'(ko0), 16'd25);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("rep_pop2", 16'(ko0), 16'd30);

      // Underflow and replace on empty
      do_reset();
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("uf_pulse", 16'(uf0),  16'd1);
      chk("uf_count", 16'(cnt0), 16'd0);
      cyc(1'b1, 1'b1, 8'd7, 8'd8);
      chk("uf_rep_pulse", 16'(uf0),  16'd1);
      chk("uf_rep_ko",    16'(ko0),  16'd7);
      chk("uf_rep_kv",    16'(kv0),  16'd1);
      chk("uf_rep_count", 16'(cnt0), 16'd1);
      cyc(1'b0, 1'b0, 8'd0, 8'd0);
      chk("uf_pulse_end", 16'(uf0), 16'd0);

      // Max-first ordering and mid-operation reset
      do_reset();
      cyc(1'b1, 1'b0, 8'd3, 8'd4);
      cyc(1'b1, 1'b0, 8'd9, 8'd10);
      cyc(1'b1, 1'b0, 8'd6, 8'd7);
      chk("max_ko",    16'(ko1),  16'd9);
      chk("max_count", 16'(cnt1), 16'd3);
      chk("min_ko",    16'(ko0),  16'd3);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 8'd8, 8'd9);
      rst = 1'b1;
      chk("max_rst_count", 16'(cnt1), 16'd0);
      chk("max_rst_kv",    16'(kv1),  16'd0);
      cyc(1'b1, 1'b0, 8'd4, 8'd5);
      chk("max_after_ko",    16'(ko1),  16'd4);
      chk("max_after_count", 16'(cnt1), 16'd1);
      cyc(1'b0, 1'b1, 8'd0, 8'd0);
      chk("max_after_empty", 16'(empty1), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sr_pq_gen.md
Name: sr_pq_gen

Overview:
- Parametrised shift-register priority queue: second generation of the stage-array PQ.
- Adds configurable min/max ordering, per-stage valid bits (no KEYINF sentinel, so the full key range is usable) and stable FIFO ordering among equal keys.
- Adds a single-cycle replace (push+pop), eviction of the worst entry when full, occupancy count and error pulses.
- Sits behind scheduler/sorter front-ends as a drop-in for the fixed-width queue.

Parameters:
KW, 16, key width in bits
VW, 16, value width in bits
DEPTH, 8, number of stages (capacity), >=2
MAX_FIRST, 0, 0 = smallest key at head; 1 = largest key at head

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
push  in  1  insert ki/vi this cycle
pop  in  1  remove head this cycle
ki  in  KW  key to insert
vi  in  VW  value to insert
ko  out  KW  head key (registered stage 0)
vo  out  VW  head value
ko_valid  out  1  head holds an entry
full  out  1  count==DEPTH
empty  out  1  count==0
count  out  $clog2(DEPTH+1)  occupancy
evict_valid  out  1  one-cycle pulse: an entry left via eviction or rejection
evict_k  out  KW  key of the entry that left
evict_v  out  VW  value of the entry that left
underflow  out  1  one-cycle pulse: pop while empty

Behaviour:
- Reset (rst==0 at posedge clk): all stage valid bits 0; count 0; empty 1; full 0; ko_valid 0; ko, vo 0; evict_valid, evict_k, evict_v 0; underflow 0. Reset mid-operation discards all contents on that edge.
- Ordering: better(a,b) = a<b (MAX_FIRST=0) or a>b (MAX_FIRST=1). Stages stay sorted, with all valid stages contiguous from stage 0.
- Insert index p: the first stage that is invalid or holds a key the new key is strictly better than. Equal keys are inserted behind existing ones (FIFO among ties).
- All outputs are registered. An operation sampled at edge t is visible after edge t; no combinational path from push/pop/ki to ko.
- Push only, not full: stages >=p take their predecessor's content, stage p takes the new entry, count+1.
- Push only, full, p<DEPTH: shift as above. The old last stage drops out to evict_* with evict_valid=1. count unchanged.
- Push only, full, p==DEPTH (new key not better than any stored): queue unchanged. The new entry itself is reported on evict_* with evict_valid=1.
- Pop only, not empty: stage j takes stage j+1, last stage becomes invalid, count-1.
- Pop only, empty: no state change; underflow=1 for one cycle.
- Push+pop, not empty (replace): p is computed on current contents; target q = max(p-1,0). Stages j<q take stage j+1, stage q takes the new entry, stages >q unchanged. count unchanged; never evicts, even when full.
- Push+pop, empty: push performed (stage 0 = new, count 1) and underflow=1.
- evict_valid and underflow are low on every cycle not named above.
- ko/vo hold their last value when ko_valid=0 (X-free).

Decomposition:
- pq_pkg gains:
  - PQ_KW, PQ_VW, PQ_CAPACITY default constants.
  - pq_order_e enum {PQ_MIN, PQ_MAX}.
  - Parameterised helper function pq_better().
- Sub-module sr_pq_gen_stage, one per stage:
  - Holds valid/key/value.
  - Computes its local "new better than me or I'm invalid" flag.
  - Selects among hold / take prev / take next / take new from its neighbours' flags plus push/pop.
- Top level handles generate array, count, eviction/underflow outputs and the p==DEPTH reject detection.

Test Plan:
All cases use DEPTH=4, KW=VW=8, MAX_FIRST=0 unless noted.
- Reset, then push keys 30,10,20 on three cycles -> ko=10 after third edge; count=3; empty=0; full=0.
- Ties: push (5,v=A) then (5,v=B), then pop twice -> vo shows A, then B; count 2->1->0; empty=1.
- Full eviction: fill 10,20,30,40, then push 15 -> evict_valid=1, evict_k=40, count=4, contents 10,15,20,30. Then push 50 -> evict_k=50 (rejected), contents unchanged.
- Replace: contents 10,20,30, push+pop key 25 -> ko=20, contents 20,25,30, count=3, evict_valid=0. Then push+pop key 5 -> ko=5, contents 5,25,30.
- Underflow/empty replace: after reset, pop -> underflow=1, count=0. Then push+pop key 7 -> underflow=1, ko=7, count=1.
- MAX_FIRST=1, mid-op reset: push 3,9,6 -> ko=9. Assert rst=0 for one edge -> count=0, ko_valid=0. Next push 4 -> ko=4.
